// File: rtl/count_mon_pkg.sv
// count_mon_pkg
// Shared types and defaults for the counter step monitor.
//   mon_state_t : monitor state (IDLE = no reference held, TRACK = reference held)
//   err_rec_t   : error record {exp, act} at the default counter width
//   WIDTH_DEF   : default monitored counter width
//   CNT_W_DEF   : default statistics counter width
package count_mon_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } mon_state_t;

   typedef logic [WIDTH_DEF-1:0] word_t;

   typedef struct packed {
      word_t exp;
      word_t act;
   } err_rec_t;

endpackage

// File: rtl/count_step_monitor_sat_counter.sv
// sat_counter
// Saturating up-counter used for the monitor statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (priority over inc)
//   inc        : increment request; ignored once the counter is at all-ones
//   cnt        : current count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/count_step_monitor.sv
// count_step_monitor
// Watches an up/down counter output and classifies every enabled sample as a
// legal +/-1 step, a stall, or an illegal jump. Wraps and errors are counted
// in saturating counters; the first unacknowledged illegal jump is offered on
// a valid/ready record port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   en, clr              : sample enable, synchronous clear (clr wins)
//   s, q_in              : counter direction select (1 = down) and counter value
//   step_ok, stall       : registered one-cycle classification pulses
//   wrap_up_cnt/dn_cnt   : saturating wrap counts (max->0, 0->max)
//   err_cnt              : saturating illegal-jump count
//   err_valid/ready      : error record handshake
//   err_exp, err_act     : expected / actual value of the pending record
//   err_ovf              : sticky, an error arrived while a record was pending
//   state                : current monitor state, for observation
//
// Handshake: a record transfers on any cycle where err_valid && err_ready are
// both high at the rising edge. err_valid then drops on that edge unless a new
// illegal jump is sampled on the same edge, in which case the new record is
// loaded and err_valid stays high. err_exp/err_act never change while
// err_valid is high and no transfer happens.
module count_step_monitor
   import count_mon_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             s,
   input  logic [WIDTH-1:0] q_in,
   output logic             step_ok,
   output logic             stall,
   output logic [CNT_W-1:0] wrap_up_cnt,
   output logic [CNT_W-1:0] wrap_dn_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_valid,
   input  logic             err_ready,
   output logic [WIDTH-1:0] err_exp,
   output logic [WIDTH-1:0] err_act,
   output logic             err_ovf,
   output mon_state_t       state
);

   typedef struct packed {
      logic [WIDTH-1:0] exp;
      logic [WIDTH-1:0] act;
   } rec_t;

   mon_state_t       state_q, state_d;
   logic [WIDTH-1:0] ref_q;
   logic             dir_q;
   rec_t             rec_q;
   logic             valid_q;
   logic             ovf_q;
   logic             step_q;
   logic             stall_q;

   logic [WIDTH-1:0] exp_val;
   logic             sample;
   logic             hit_step;
   logic             hit_stall;
   logic             illegal;
   logic             wrap_up;
   logic             wrap_dn;
   logic             xfer;

   // The counter's q at this edge reflects the direction applied one edge
   // earlier, so the expectation uses the previously captured direction.
   assign exp_val = dir_q ? (ref_q - 1'b1) : (ref_q + 1'b1);

   always_comb begin
      state_d   = state_q;
      sample    = 1'b0;
      hit_step  = 1'b0;
      hit_stall = 1'b0;
      illegal   = 1'b0;
      wrap_up   = 1'b0;
      wrap_dn   = 1'b0;
      if (clr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) state_d = TRACK;
            end
            TRACK: begin
               sample = en;
               if (en) begin
                  if (q_in == exp_val) begin
                     hit_step = 1'b1;
                     wrap_up  = !dir_q && (ref_q == {WIDTH{1'b1}});
                     wrap_dn  = dir_q && (ref_q == '0);
                  end else if (q_in == ref_q) begin
                     hit_stall = 1'b1;
                  end else begin
                     illegal = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign xfer = valid_q && err_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Reference value and direction: captured on every enabled sample, which
   // also resynchronises the reference after an illegal jump.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q <= '0;
         dir_q <= 1'b0;
      end else if (clr) begin
         ref_q <= '0;
         dir_q <= 1'b0;
      end else if (en) begin
         ref_q <= q_in;
         dir_q <= s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q  <= 1'b0;
         stall_q <= 1'b0;
      end else if (clr) begin
         step_q  <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         step_q  <= hit_step;
         stall_q <= hit_stall;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         rec_q   <= '0;
      end else if (clr) begin
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         rec_q   <= '0;
      end else if (illegal) begin
         // A slot frees up when the pending record leaves on this same edge.
         if (!valid_q || xfer) begin
            valid_q   <= 1'b1;
            rec_q.exp <= exp_val;
            rec_q.act <= q_in;
         end else begin
            ovf_q <= 1'b1;
         end
      end else if (xfer) begin
         valid_q <= 1'b0;
      end
   end

   sat_counter #(.W(CNT_W)) u_wrap_up (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (wrap_up),
      .cnt   (wrap_up_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wrap_dn (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (wrap_dn),
      .cnt   (wrap_dn_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (illegal && sample),
      .cnt   (err_cnt)
   );

   assign step_ok   = step_q;
   assign stall     = stall_q;
   assign err_valid = valid_q;
   assign err_exp   = rec_q.exp;
   assign err_act   = rec_q.act;
   assign err_ovf   = ovf_q;
   assign state     = state_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// tb_count_step_monitor
// Directed and randomized bench for count_step_monitor with a behavioural
// reference model of the monitoring rules.
module tb_count_step_monitor;
   import count_mon_pkg::*;

   localparam int W   = 4;
   localparam int CW  = 8;
   localparam int MOD = 16;
   localparam int SAT = 255;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic          s = 1'b0;
   logic [W-1:0]  q_in = '0;
   logic          step_ok;
   logic          stall;
   logic [CW-1:0] wrap_up_cnt;
   logic [CW-1:0] wrap_dn_cnt;
   logic [CW-1:0] err_cnt;
   logic          err_valid;
   logic          err_ready = 1'b0;
   logic [W-1:0]  err_exp;
   logic [W-1:0]  err_act;
   logic          err_ovf;
   mon_state_t    state;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit m_track;
   int m_ref;
   bit m_dir;
   bit m_step, m_stall;
   int m_wu, m_wd, m_ec;
   bit m_valid, m_ovf;
   int m_exp, m_act;

   count_step_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .clr         (clr),
      .s           (s),
      .q_in        (q_in),
      .step_ok     (step_ok),
      .stall       (stall),
      .wrap_up_cnt (wrap_up_cnt),
      .wrap_dn_cnt (wrap_dn_cnt),
      .err_cnt     (err_cnt),
      .err_valid   (err_valid),
      .err_ready   (err_ready),
      .err_exp     (err_exp),
      .err_act     (err_act),
      .err_ovf     (err_ovf),
      .state       (state)
   );

   always #5 clk = ~clk;

   function automatic int sat_inc(int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   function automatic int model_exp();
      return m_dir ? (m_ref + MOD - 1) % MOD : (m_ref + 1) % MOD;
   endfunction

   task automatic model_reset();
      m_track = 0; m_ref = 0; m_dir = 0; m_step = 0; m_stall = 0;
      m_wu = 0; m_wd = 0; m_ec = 0; m_valid = 0; m_ovf = 0;
      m_exp = 0; m_act = 0;
   endtask

   // One rising edge of the monitoring rules.
   task automatic model_edge(input bit e, input bit sv, input int qv, input bit rdy, input bit c);
      bit nv;
      int ev;
      if (c) begin
         model_reset();
         return;
      end
      m_step = 0;
      m_stall = 0;
      nv = m_valid && !(m_valid && rdy);
      if (e) begin
         if (!m_track) begin
            m_track = 1;
         end else begin
            ev = model_exp();
            if (qv == ev) begin
               m_step = 1;
               if (!m_dir && m_ref == MOD - 1) m_wu = sat_inc(m_wu);
               if (m_dir && m_ref == 0) m_wd = sat_inc(m_wd);
            end else if (qv == m_ref) begin
               m_stall = 1;
            end else begin
               m_ec = sat_inc(m_ec);
               if (!m_valid || rdy) begin
                  nv = 1; m_exp = ev; m_act = qv;
               end else begin
                  m_ovf = 1;
               end
            end
         end
         m_ref = qv;
         m_dir = sv;
      end
      m_valid = nv;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".step_ok"},   int'(step_ok),     int'(m_step));
      check({tag, ".stall"},     int'(stall),       int'(m_stall));
      check({tag, ".wrap_up"},   int'(wrap_up_cnt), m_wu);
      check({tag, ".wrap_dn"},   int'(wrap_dn_cnt), m_wd);
      check({tag, ".err_cnt"},   int'(err_cnt),     m_ec);
      check({tag, ".err_valid"}, int'(err_valid),   int'(m_valid));
      check({tag, ".err_exp"},   int'(err_exp),     m_exp);
      check({tag, ".err_act"},   int'(err_act),     m_act);
      check({tag, ".err_ovf"},   int'(err_ovf),     int'(m_ovf));
      check({tag, ".track"},     int'(state == TRACK), int'(m_track));
   endtask

   // Drive one cycle of inputs, step the model at the edge, check after it.
   task automatic smp(input string tag, input bit e, input bit sv, input int qv,
                      input bit rdy, input bit c);
      @(negedge clk);
      en = e; s = sv; q_in = W'(qv); err_ready = rdy; clr = c;
      @(posedge clk);
      model_edge(e, sv, qv, rdy, c);
      #1;
      check_all(tag);
   endtask

   initial begin
      int q;
      int kind;
      model_reset();

      // reset
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // up counting through the max->0 wrap
      smp("up14", 1, 0, 14, 0, 0);
      smp("up15", 1, 0, 15, 0, 0);
      smp("up0",  1, 0, 0,  0, 0);
      smp("up1",  1, 0, 1,  0, 0);
      check("up_wrap_cnt", int'(wrap_up_cnt), 1);
      check("up_err_cnt",  int'(err_cnt), 0);

      // down counting with a skipped range
      smp("dn_clr", 0, 0, 0, 0, 1);
      smp("dn15", 1, 1, 15, 0, 0);
      smp("dn14", 1, 1, 14, 0, 0);
      smp("dn13", 1, 1, 13, 0, 0);
      smp("dn8",  1, 1, 8,  0, 0);
      check("dn_err_exp", int'(err_exp), 12);
      check("dn_err_act", int'(err_act), 8);
      smp("dn7",  1, 1, 7,  0, 0);
      check("dn_step_after_err", int'(step_ok), 1);
      smp("dn_ack", 0, 1, 7, 1, 0);

      // direction change: dir_d lags s by one sample
      smp("dc_clr", 0, 0, 0, 0, 1);
      smp("dc8",  1, 0, 8,  0, 0);
      smp("dc9",  1, 0, 9,  0, 0);
      smp("dc10", 1, 1, 10, 0, 0);
      smp("dc9b", 1, 1, 9,  0, 0);
      check("dc_no_err", int'(err_cnt), 0);

      // two errors with no consumer, then acknowledge
      smp("ov_clr", 0, 0, 0, 0, 1);
      smp("ov0", 1, 0, 0, 0, 0);
      smp("ov5", 1, 0, 5, 0, 0);
      smp("ov9", 1, 0, 9, 0, 0);
      check("ov_flag",   int'(err_ovf), 1);
      check("ov_cnt",    int'(err_cnt), 2);
      check("ov_rec_ex", int'(err_exp), 1);
      check("ov_rec_ac", int'(err_act), 5);
      smp("ov_ack", 0, 0, 9, 1, 0);
      check("ov_ack_clears", int'(err_valid), 0);

      // error in the same cycle as a transfer keeps valid and sets no overflow
      smp("sx_clr", 0, 0, 0, 0, 1);
      smp("sx0", 1, 0, 0, 0, 0);
      smp("sx7", 1, 0, 7, 0, 0);
      smp("sx3", 1, 0, 3, 1, 0);
      check("sx_ovf", int'(err_ovf), 0);

      // stalls, then saturation of the error counter
      smp("st_clr", 0, 0, 0, 0, 1);
      smp("st5a", 1, 0, 5, 0, 0);
      smp("st5b", 1, 0, 5, 0, 0);
      smp("st5c", 1, 0, 5, 0, 0);
      check("st_no_err", int'(err_cnt), 0);
      q = 5;
      for (int i = 0; i < 260; i++) begin
         q = (q + 5) % MOD;
         smp("sat", 1, 0, q, 0, 0);
      end
      check("sat_hold", int'(err_cnt), SAT);

      // clear, then capture-only first sample
      smp("clr", 0, 0, 0, 0, 1);
      smp("cap3", 1, 0, 3, 0, 0);
      check("cap_no_step", int'(step_ok), 0);
      smp("cap4", 1, 0, 4, 0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         kind = $urandom_range(0, 9);
         if (!m_track) q = $urandom_range(0, MOD - 1);
         else if (kind < 6) q = model_exp();
         else if (kind < 8) q = m_ref;
         else q = $urandom_range(0, MOD - 1);
         smp("rnd", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), q,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
      end

      // asynchronous reset while a record is pending
      smp("ar_clr", 0, 0, 0, 0, 1);
      smp("ar0", 1, 0, 0, 0, 0);
      smp("ar6", 1, 0, 6, 0, 0);
      check("ar_pending", int'(err_valid), 1);
      @(negedge clk);
      en = 1'b0; err_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      err_ready = 1'b0;
      @(posedge clk);
      #1;
      check_all("after_rst");
      smp("post0", 1, 0, 2, 0, 0);
      smp("post1", 1, 0, 3, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/count_step_monitor.md
# count_step_monitor

Checks the output of the 4-bit synchronous up/down counter on every sampled cycle. It sits directly downstream of the counter, taking the counter's `q` and its direction select `s`. Each sample is classified as a legal ±1 step, a stall or an illegal jump, and up/down wrap-arounds are counted. The first unacknowledged illegal jump is presented as an error record on a valid/ready port, so the test harness and the status logic can catch counter faults such as skipped states.

## Interface
- `WIDTH`, 4: counter width in bits.
- `CNT_W`, 8: width of each statistics counter; all statistics counters saturate.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `en`, in, 1: sample enable; `q_in` and `s` are sampled when this is 1.
- `clr`, in, 1: synchronous clear of all state and statistics.
- `s`, in, 1: counter direction select, as driven to the counter (1 = down, 0 = up).
- `q_in`, in, WIDTH: counter output `q`.
- `step_ok`, out, 1: one-cycle pulse for a legal ±1 step.
- `stall`, out, 1: one-cycle pulse when the sample equals the reference.
- `wrap_up_cnt`, out, CNT_W: number of up-wraps, max → 0.
- `wrap_dn_cnt`, out, CNT_W: number of down-wraps, 0 → max.
- `err_cnt`, out, CNT_W: number of illegal jumps.
- `err_valid`, out, 1: an error record is pending.
- `err_ready`, in, 1: consumer accepts the pending record.
- `err_exp`, out, WIDTH: expected value held in the pending record.
- `err_act`, out, WIDTH: actual value held in the pending record.
- `err_ovf`, out, 1: sticky flag; an error occurred while a record was already pending.

## Operation
- State machine states:
  - `IDLE`: no reference value held.
  - `TRACK`: a reference `ref_q` and a registered direction `dir_d` are held.
- In `IDLE`, on `en`:
  - `ref_q` ← `q_in`, `dir_d` ← `s`.
  - Go to `TRACK`.
  - No classification is made.
- Direction used for checking: the counter's `q` at edge N reflects the direction applied at edge N−1. The expected value is therefore computed from `dir_d`, the `s` captured at the previous sample, not from the current `s`.
- Expected value: `exp` = `ref_q` − 1 when `dir_d` = 1, else `ref_q` + 1. The arithmetic is modulo 2^WIDTH.
- In `TRACK`, on `en`, the sample is classified:
  - `q_in` == `exp`: pulse `step_ok`.
    - Up with `ref_q` = 2^WIDTH−1: also increment `wrap_up_cnt`.
    - Down with `ref_q` = 0: also increment `wrap_dn_cnt`.
  - `q_in` == `ref_q`: pulse `stall`; this is not an error.
  - Otherwise: illegal jump.
    - Increment `err_cnt`.
    - If `err_valid` = 0: load `err_exp` ← `exp`, `err_act` ← `q_in`, and set `err_valid`.
    - If `err_valid` = 1: drop the record and set `err_ovf`.
- After every `TRACK` sample: `ref_q` ← `q_in` (resync after an error) and `dir_d` ← `s`.
- When `en` = 0: no state changes except the handshake.
- Handshake:
  - A record transfers on a cycle where `err_valid` && `err_ready`; `err_valid` clears on the next edge.
  - If an error occurs in the same cycle as a transfer, the new record is loaded, `err_valid` stays 1, and `err_ovf` is not set.
  - `err_exp` and `err_act` stay stable while `err_valid` = 1.
- Saturation: a statistics counter at 2^CNT_W−1 holds its value.
- `clr` has priority over `en` and the handshake. It returns the block to `IDLE` and zeroes all counters, `err_valid` and `err_ovf`.
- With WIDTH=4, wrap detection applies to the boundaries 15 and 0.

## Timing
- Reset values: state `IDLE`; `ref_q`=0, `dir_d`=0; every output is 0.
- Reset takes effect immediately (asynchronous); deassertion is synchronised by the existing reset logic.
- `step_ok`, `stall` and the counter updates are registered: they are visible 1 cycle after the sampling edge.
- `err_valid` rises 1 cycle after the offending sample.
- A reset in the middle of a transfer discards the pending record.
- First `en` after reset or `clr` performs capture only. The first classification happens on the second `en`.

## Structure
- Package `count_mon_pkg` holds:
  - the state enum (`IDLE`, `TRACK`);
  - an error-record struct `{exp, act}`, parameterised by WIDTH through a typedef;
  - the default values for WIDTH and CNT_W.
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst_n`, `clr`, `inc`, `cnt`) is instantiated three times, for the up-wrap, down-wrap and error counts.
- Expected target: about 150–250 lines of RTL in total.

## Test plan
- Up counting: reset, `s`=0, `en`=1, `q_in` stepping 14,15,0,1 → `step_ok` on the last three samples, `wrap_up_cnt`=1, `err_cnt`=0.
- Down counting through a skip: `s`=1, `q_in` 15,14,13,8,7 → `err_valid` with `err_exp`=12, `err_act`=8; `err_cnt`=1; the sample 8→7 gives `step_ok`.
- Direction change: `s` goes 0→1 between samples 9 and 10. With `q_in` 9,10,9 → no error, because `dir_d` lags `s` by one sample.
- Errors with `err_ready`=0:
  - Two illegal jumps → `err_ovf`=1, `err_cnt`=2, and the record holds the first error.
  - Then `err_ready`=1 → `err_valid` clears one cycle later.
- Clear and saturation:
  - Stall `q_in`=5 ×3 → `stall` pulses and no error.
  - Force 260 errors → `err_cnt` holds at 255.
  - `clr` → all outputs 0, and the next sample is capture-only.
- Reset mid-operation: assert `rst_n`=0 between clock edges while `err_valid`=1 → all outputs 0 immediately; the block is in `IDLE` after release.
